// File: rtl/grf_wb_queue.sv
// Register-file writeback queue: merges ALU and MUL/DIV writebacks into one GRF write port.
// Optional pending-write forwarding lookup is compiled in with GRF_WB_BYPASS_EN.
module grf_wb_queue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     res,
   input  logic                     alu_valid,
   input  logic [4:0]               alu_a3,
   input  logic [31:0]              alu_wd,
   output logic                     alu_ready,
   input  logic                     md_valid,
   input  logic [4:0]               md_a3,
   input  logic [31:0]              md_wd,
   output logic                     md_ready,
   output logic                     grf_we,
   output logic [4:0]               grf_a3,
   output logic [31:0]              grf_wd,
   input  logic [4:0]               q_a1,
   input  logic [4:0]               q_a2,
   output logic                     hit1,
   output logic                     hit2,
   output logic [31:0]              fwd1,
   output logic [31:0]              fwd2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = DEPTH[PW:0];

   logic [PW-1:0] r_rd_ptr, r_wr_ptr;
   logic [PW:0]   r_count, w_count_nxt;
   logic [4:0]    r_a3 [DEPTH];
   logic [31:0]   r_wd [DEPTH];

   logic        w_full, w_alu_acc, w_md_acc, w_push, w_pop;
   logic [4:0]  w_push_a3;
   logic [31:0] w_push_wd;

   assign w_full    = (r_count == FULL);
   assign alu_ready = !w_full;
   assign md_ready  = !w_full && !alu_valid;

   assign w_alu_acc = alu_valid && alu_ready && !res;
   assign w_md_acc  = md_valid && md_ready && !res;
   assign w_push_a3 = w_alu_acc ? alu_a3 : md_a3;
   assign w_push_wd = w_alu_acc ? alu_wd : md_wd;
   // Writes to x0 are accepted but dropped.
   assign w_push    = (w_alu_acc || w_md_acc) && (w_push_a3 != 5'd0);
   assign w_pop     = (r_count != '0);

   assign grf_we = w_pop;
   assign grf_a3 = w_pop ? r_a3[r_rd_ptr] : 5'd0;
   assign grf_wd = w_pop ? r_wd[r_rd_ptr] : 32'd0;
   assign count  = r_count;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + (PW+1)'(1);
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= w_count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_a3[r_wr_ptr] <= w_push_a3;
         r_wd[r_wr_ptr] <= w_push_wd;
      end
   end

`ifdef GRF_WB_BYPASS_EN
   // Scan oldest to newest so the newest matching entry wins.
   function automatic logic [32:0] lookup(input logic [4:0] q);
      logic [32:0]   res_v;
      logic [PW-1:0] idx;
      res_v = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = r_rd_ptr + PW'(i);
         if (((PW+1)'(i) < r_count) && (q != 5'd0) && (r_a3[idx] == q)) begin
            res_v = {1'b1, r_wd[idx]};
         end
      end
      return res_v;
   endfunction

   always_comb begin
      {hit1, fwd1} = lookup(q_a1);
      {hit2, fwd2} = lookup(q_a2);
   end
`else
   logic w_unused_q;
   assign w_unused_q = ^{q_a1, q_a2};
   assign hit1 = 1'b0;
   assign hit2 = 1'b0;
   assign fwd1 = 32'd0;
   assign fwd2 = 32'd0;
`endif

endmodule
